// File: rtl/exe_stage_unit_if.sv
// rtl/exe_stage_unit_if.sv - ID/EXE inputs, forwarding, branch and EXE/MEM outputs of the execute stage
interface exe_stage_unit_if;
    logic        freeze;
    logic        WB_en_in;
    logic        MEM_R_en_in;
    logic        MEM_W_en_in;
    logic        B_in;
    logic        S_in;
    logic        imm_in;
    logic [3:0]  EXE_CMD_in;
    logic [3:0]  Dest_in;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [31:0] PC_in;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] fwd_mem;
    logic [31:0] fwd_wb;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic [3:0]  Status_out;
    logic        WB_en;
    logic        MEM_R_en;
    logic        MEM_W_en;
    logic [31:0] ALU_res;
    logic [31:0] ST_val;
    logic [3:0]  Dest;

    // Upstream side: drives the decoded instruction, sees the stage results
    modport master (
        output freeze, WB_en_in, MEM_R_en_in, MEM_W_en_in, B_in, S_in, imm_in,
        output EXE_CMD_in, Dest_in, Shift_operand, Signed_imm_24, PC_in,
        output Val_Rn, Val_Rm, sel_src1, sel_src2, fwd_mem, fwd_wb,
        input  Br_taken, Br_addr, Status_out, WB_en, MEM_R_en, MEM_W_en,
        input  ALU_res, ST_val, Dest
    );

    // Execute stage side
    modport slave (
        input  freeze, WB_en_in, MEM_R_en_in, MEM_W_en_in, B_in, S_in, imm_in,
        input  EXE_CMD_in, Dest_in, Shift_operand, Signed_imm_24, PC_in,
        input  Val_Rn, Val_Rm, sel_src1, sel_src2, fwd_mem, fwd_wb,
        output Br_taken, Br_addr, Status_out, WB_en, MEM_R_en, MEM_W_en,
        output ALU_res, ST_val, Dest
    );
endinterface

// File: rtl/exe_stage_unit.sv
// rtl/exe_stage_unit.sv - ARM execute stage with EXE/MEM register and NZCV status register
module exe_stage_unit #(
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    exe_stage_unit_if.slave    bus
);

    logic [DW-1:0]   op1;
    logic [DW-1:0]   rm;
    logic [DW-1:0]   val2;
    logic [DW-1:0]   shifted;
    logic [2*DW-1:0] imm_rot;
    logic [2*DW-1:0] rm_rot;
    logic [4:0]      imm5;
    logic [DW:0]     sum;
    logic [DW-1:0]   alu_res;
    logic            n_q, z_q, c_q, v_q;
    logic            c_new, v_new;
    logic            flags_valid;

    assign imm5 = bus.Shift_operand[11:7];

    // Branch resolution is purely combinational so IF can redirect in the same cycle
    assign bus.Br_taken = bus.B_in;
    assign bus.Br_addr  = bus.PC_in + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};

    // Operand forwarding muxes; 11 falls back to the register-file value
    always_comb begin
        case (bus.sel_src1)
            2'b01:   op1 = bus.fwd_mem;
            2'b10:   op1 = bus.fwd_wb;
            default: op1 = bus.Val_Rn;
        endcase
        case (bus.sel_src2)
            2'b01:   rm = bus.fwd_mem;
            2'b10:   rm = bus.fwd_wb;
            default: rm = bus.Val_Rm;
        endcase
    end

    // Val2 generation: rotated immediate, raw offset for loads/stores, or shifted Rm
    always_comb begin
        imm_rot = {24'b0, bus.Shift_operand[7:0], 24'b0, bus.Shift_operand[7:0]}
                  >> {bus.Shift_operand[11:8], 1'b0};
        rm_rot  = {rm, rm} >> imm5;
        case (bus.Shift_operand[6:5])
            2'b00:   shifted = rm << imm5;
            2'b01:   shifted = rm >> imm5;
            2'b10:   shifted = $unsigned($signed(rm) >>> imm5);
            default: shifted = rm_rot[DW-1:0];
        endcase
        if (bus.imm_in) begin
            val2 = imm_rot[DW-1:0];
        end else if (bus.MEM_R_en_in || bus.MEM_W_en_in) begin
            val2 = {20'b0, bus.Shift_operand};
        end else begin
            val2 = shifted;
        end
    end

    // ALU; subtraction is done as op1 + ~Val2 + carry so C comes out as NOT borrow
    always_comb begin
        sum         = '0;
        alu_res     = '0;
        c_new       = c_q;
        v_new       = v_q;
        flags_valid = 1'b1;
        case (bus.EXE_CMD_in)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                sum     = {1'b0, op1} + {1'b0, val2}
                          + {{DW{1'b0}}, (bus.EXE_CMD_in[0] & c_q)};
                alu_res = sum[DW-1:0];
                c_new   = sum[DW];
                v_new   = (op1[DW-1] == val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
            end
            4'b0100, 4'b0101: begin
                sum     = {1'b0, op1} + {1'b0, ~val2}
                          + {{DW{1'b0}}, (bus.EXE_CMD_in[0] ? c_q : 1'b1)};
                alu_res = sum[DW-1:0];
                c_new   = sum[DW];
                v_new   = (op1[DW-1] != val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
            end
            4'b0110: alu_res = op1 & val2;
            4'b0111: alu_res = op1 | val2;
            4'b1000: alu_res = op1 ^ val2;
            default: flags_valid = 1'b0;
        endcase
    end

    // EXE/MEM pipeline register, held while memory stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.WB_en    <= 1'b0;
            bus.MEM_R_en <= 1'b0;
            bus.MEM_W_en <= 1'b0;
            bus.ALU_res  <= '0;
            bus.ST_val   <= '0;
            bus.Dest     <= '0;
        end else if (!bus.freeze) begin
            bus.WB_en    <= bus.WB_en_in;
            bus.MEM_R_en <= bus.MEM_R_en_in;
            bus.MEM_W_en <= bus.MEM_W_en_in;
            bus.ALU_res  <= alu_res;
            bus.ST_val   <= rm;
            bus.Dest     <= bus.Dest_in;
        end
    end

    // NZCV status register, written only by S-bit instructions with a defined opcode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {n_q, z_q, c_q, v_q} <= 4'b0;
        end else if (!bus.freeze && bus.S_in && flags_valid) begin
            n_q <= alu_res[DW-1];
            z_q <= (alu_res == '0);
            c_q <= c_new;
            v_q <= v_new;
        end
    end

    assign bus.Status_out = {n_q, z_q, c_q, v_q};

endmodule
